// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: grants WALK at red entry, then a flashing DON'T-WALK clearance, with a sticky light-stream fault.
// Latency: walk/ack assert on the same posedge that sees red_rise; all outputs are registered.
// Backpressure: none; a button press is held as pending until the next red entry is granted.
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES = 1,
    parameter int MAX_PHASE   = 4,
    parameter int PH_W        = 3,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             y,
    input  logic             g,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             ped_wait,
    output logic             ack,
    output logic             fault,
    output logic [CNT_W-1:0] serve_cnt
);

    localparam int TMR_W = $clog2(WALK_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_CLEAR, S_FAULT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         prev_q;
    logic               prev_valid_q;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pending_q, pending_d;
    logic               walk_q, walk_d;
    logic               dont_walk_q, dont_walk_d;
    logic               ack_q, ack_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   serve_q, serve_d;

    logic [2:0] cur;
    logic       one_hot, same, legal_step, bad_trans, stuck, fault_now;
    logic       red_rise, pend_n;

    assign cur = {r, y, g};

    // Light-stream checks: pattern, transition legality and phase run length.
    always_comb begin
        one_hot    = (cur == 3'b100) || (cur == 3'b010) || (cur == 3'b001);
        same       = prev_valid_q && (cur == prev_q);
        // r->y->g->r is a one-position right rotation of {r,y,g}
        legal_step = (cur == {prev_q[0], prev_q[2:1]});
        bad_trans  = prev_valid_q && !same && !legal_step;
        if (!same) begin
            phase_d = PH_W'(1);
        end else if (phase_q == PH_W'(MAX_PHASE + 1)) begin
            phase_d = phase_q;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
        stuck     = (phase_d > PH_W'(MAX_PHASE));
        fault_now = !one_hot || bad_trans || stuck;
        red_rise  = r && !prev_q[2] && prev_valid_q;
        pend_n    = ped_btn || pending_q;
    end

    // Next-state and registered-output decode; fault overrides everything.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pending_d   = pend_n;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        ack_d       = 1'b0;
        fault_d     = fault_q;
        serve_d     = serve_q;
        if ((state_q == S_FAULT) || fault_now) begin
            state_d   = S_FAULT;
            fault_d   = 1'b1;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (red_rise && pend_n) begin
                        state_d     = S_WALK;
                        walk_d      = 1'b1;
                        dont_walk_d = 1'b0;
                        ack_d       = 1'b1;
                        pending_d   = 1'b0;
                        timer_d     = TMR_W'(1);
                        if (!(&serve_q)) serve_d = serve_q + CNT_W'(1);
                    end
                end
                S_WALK: begin
                    if (!r) begin
                        state_d = S_IDLE;
                    end else if (timer_q >= TMR_W'(WALK_CYCLES)) begin
                        state_d = S_CLEAR;
                    end else begin
                        timer_d     = timer_q + TMR_W'(1);
                        walk_d      = 1'b1;
                        dont_walk_d = 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (!r) begin
                        state_d = S_IDLE;
                    end else begin
                        dont_walk_d = !dont_walk_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and history registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prev_q       <= 3'b000;
            prev_valid_q <= 1'b0;
            phase_q      <= '0;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            walk_q       <= 1'b0;
            dont_walk_q  <= 1'b1;
            ack_q        <= 1'b0;
            fault_q      <= 1'b0;
            serve_q      <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= cur;
            prev_valid_q <= 1'b1;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            walk_q       <= walk_d;
            dont_walk_q  <= dont_walk_d;
            ack_q        <= ack_d;
            fault_q      <= fault_d;
            serve_q      <= serve_d;
        end
    end

    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign ped_wait  = pending_q;
    assign ack       = ack_q;
    assign fault     = fault_q;
    assign serve_cnt = serve_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: vector table, directed corner sequences, random stream vs model.
// Two instances run in lockstep: WALK_CYCLES=1 and WALK_CYCLES=3.
// Inputs change on negedge, outputs are sampled 1 time unit after posedge.
module tb_ped_crossing_ctrl;

    localparam int MAXP = 4;

    logic       clk = 1'b0;
    logic       rst, r, y, g, ped_btn;
    logic [1:0] walk_w, dw_w, wait_w, ack_w, fault_w;
    logic [3:0] cnt_w [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    ped_crossing_ctrl #(.WALK_CYCLES(1), .MAX_PHASE(4), .PH_W(3), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .r(r), .y(y), .g(g), .ped_btn(ped_btn),
        .walk(walk_w[0]), .dont_walk(dw_w[0]), .ped_wait(wait_w[0]), .ack(ack_w[0]),
        .fault(fault_w[0]), .serve_cnt(cnt_w[0]));

    ped_crossing_ctrl #(.WALK_CYCLES(3), .MAX_PHASE(4), .PH_W(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .r(r), .y(y), .g(g), .ped_btn(ped_btn),
        .walk(walk_w[1]), .dont_walk(dw_w[1]), .ped_wait(wait_w[1]), .ack(ack_w[1]),
        .fault(fault_w[1]), .serve_cnt(cnt_w[1]));

    // Reference model: lights as indices 0=r,1=y,2=g; a legal step is +1 mod 3.
    // A granted red is described by its age in cycles since the grant edge.
    int WC [2] = '{1, 3};
    bit m_have [2], m_prev_r [2], m_fault [2], m_pend [2], m_grant [2], m_ack [2];
    int m_last [2], m_run [2], m_age [2], m_served [2];

    task automatic model_step(input int m, input bit rs, input bit [2:0] rgb, input bit btn);
        int  ones, idx;
        bit  bad, rr;
        if (rs) begin
            m_have[m] = 0; m_prev_r[m] = 0; m_fault[m] = 0; m_pend[m] = 0;
            m_grant[m] = 0; m_ack[m] = 0; m_last[m] = 0; m_run[m] = 0;
            m_age[m] = 0; m_served[m] = 0;
            return;
        end
        ones = int'(rgb[2]) + int'(rgb[1]) + int'(rgb[0]);
        idx  = rgb[2] ? 0 : (rgb[1] ? 1 : 2);
        rr   = m_have[m] && rgb[2] && !m_prev_r[m];
        bad  = (ones != 1);
        if (m_have[m] && !bad && idx != m_last[m] && ((idx - m_last[m] + 3) % 3) != 1) bad = 1;
        if (m_have[m] && idx == m_last[m]) m_run[m] = (m_run[m] + 1 > MAXP + 1) ? MAXP + 1 : m_run[m] + 1;
        else m_run[m] = 1;
        if (m_run[m] > MAXP) bad = 1;
        m_prev_r[m] = rgb[2];
        m_last[m]   = idx;
        m_have[m]   = 1;
        m_ack[m]    = 0;
        if (m_fault[m] || bad) begin
            m_fault[m] = 1; m_pend[m] = 0; m_grant[m] = 0;
        end else if (rr && (btn || m_pend[m])) begin
            m_grant[m] = 1; m_age[m] = 0; m_pend[m] = 0; m_ack[m] = 1;
            if (m_served[m] < 15) m_served[m]++;
        end else begin
            m_pend[m] = m_pend[m] | btn;
            if (m_grant[m]) begin
                if (!rgb[2]) m_grant[m] = 0;
                else m_age[m]++;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input int m);
        bit e_walk, e_dw;
        if (m_fault[m] || !m_grant[m]) begin
            e_walk = 0; e_dw = 1;
        end else if (m_age[m] < WC[m]) begin
            e_walk = 1; e_dw = 0;
        end else begin
            e_walk = 0; e_dw = (((m_age[m] - WC[m]) % 2) == 0);
        end
        check($sformatf("c%0d.dut%0d.walk", cyc, m), int'(walk_w[m]), int'(e_walk));
        check($sformatf("c%0d.dut%0d.dont_walk", cyc, m), int'(dw_w[m]), int'(e_dw));
        check($sformatf("c%0d.dut%0d.ped_wait", cyc, m), int'(wait_w[m]), int'(m_pend[m]));
        check($sformatf("c%0d.dut%0d.ack", cyc, m), int'(ack_w[m]), int'(m_ack[m]));
        check($sformatf("c%0d.dut%0d.fault", cyc, m), int'(fault_w[m]), int'(m_fault[m]));
        check($sformatf("c%0d.dut%0d.serve_cnt", cyc, m), int'(cnt_w[m]), m_served[m]);
    endtask

    task automatic step(input bit rs, input bit [2:0] rgb, input bit btn);
        @(negedge clk);
        rst = rs; r = rgb[2]; y = rgb[1]; g = rgb[0]; ped_btn = btn;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, rs, rgb, btn);
        #1;
        cyc++;
        for (int m = 0; m < 2; m++) check_model(m);
    endtask

    typedef struct {
        bit       rs;
        bit [2:0] rgb;
        bit       btn;
        bit [4:0] exp; // {walk, dont_walk, ped_wait, ack, fault}
        int       cnt;
    } vec_t;

    function automatic vec_t mk(input bit rs, input bit [2:0] rgb, input bit btn,
                                input bit [4:0] e, input int c);
        vec_t v;
        v.rs = rs; v.rgb = rgb; v.btn = btn; v.exp = e; v.cnt = c;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        bit [2:0] rgb;
        int gidx, glen;
        rst = 1'b1; r = 1'b1; y = 1'b0; g = 1'b0; ped_btn = 1'b0;

        // Expected outputs for the WALK_CYCLES=1 instance after each edge.
        tbl.push_back(mk(1, 3'b100, 0, 5'b01000, 0)); // reset values
        tbl.push_back(mk(0, 3'b100, 0, 5'b01000, 0)); // first sample: no red_rise
        tbl.push_back(mk(0, 3'b010, 0, 5'b01000, 0));
        tbl.push_back(mk(0, 3'b010, 0, 5'b01000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01000, 0));
        tbl.push_back(mk(0, 3'b001, 1, 5'b01100, 0)); // press in green
        tbl.push_back(mk(0, 3'b100, 0, 5'b10010, 1)); // red_rise: WALK + ack
        tbl.push_back(mk(0, 3'b100, 0, 5'b01000, 1)); // CLEAR
        tbl.push_back(mk(0, 3'b010, 0, 5'b01000, 1)); // IDLE
        tbl.push_back(mk(0, 3'b010, 0, 5'b01000, 1));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01000, 1));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01000, 1));
        tbl.push_back(mk(0, 3'b100, 1, 5'b10010, 2)); // press on red_rise served at once
        tbl.push_back(mk(0, 3'b100, 1, 5'b01100, 2)); // press during WALK held
        tbl.push_back(mk(0, 3'b010, 0, 5'b01100, 2));
        tbl.push_back(mk(0, 3'b010, 0, 5'b01100, 2));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01100, 2));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01100, 2));
        tbl.push_back(mk(0, 3'b100, 0, 5'b10010, 3)); // held press served
        tbl.push_back(mk(0, 3'b100, 0, 5'b01000, 3));
        tbl.push_back(mk(0, 3'b010, 0, 5'b01000, 3));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01000, 3));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01000, 3));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01000, 3));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01000, 3)); // 4th green: still legal
        tbl.push_back(mk(0, 3'b001, 0, 5'b01001, 3)); // 5th green: stuck fault
        tbl.push_back(mk(0, 3'b100, 1, 5'b01001, 3)); // red_rise + press ignored
        tbl.push_back(mk(1, 3'b100, 0, 5'b01000, 0)); // rst clears fault
        tbl.push_back(mk(0, 3'b100, 0, 5'b01000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 5'b01001, 0)); // r->g illegal
        tbl.push_back(mk(1, 3'b110, 0, 5'b01000, 0)); // reset wins over bad pattern
        tbl.push_back(mk(0, 3'b110, 0, 5'b01001, 0)); // not one-hot
        tbl.push_back(mk(1, 3'b100, 0, 5'b01000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rs, tbl[i].rgb, tbl[i].btn);
            check($sformatf("tbl%0d.walk", i), int'(walk_w[0]), int'(tbl[i].exp[4]));
            check($sformatf("tbl%0d.dont_walk", i), int'(dw_w[0]), int'(tbl[i].exp[3]));
            check($sformatf("tbl%0d.ped_wait", i), int'(wait_w[0]), int'(tbl[i].exp[2]));
            check($sformatf("tbl%0d.ack", i), int'(ack_w[0]), int'(tbl[i].exp[1]));
            check($sformatf("tbl%0d.fault", i), int'(fault_w[0]), int'(tbl[i].exp[0]));
            check($sformatf("tbl%0d.serve_cnt", i), int'(cnt_w[0]), tbl[i].cnt);
        end

        // Long red: CLEAR flashes 1,0,1 after a single WALK cycle.
        step(0, 3'b100, 0); step(0, 3'b010, 0); step(0, 3'b010, 0);
        step(0, 3'b001, 0); step(0, 3'b001, 1);
        step(0, 3'b100, 0); check("flash.walk", int'(walk_w[0]), 1);
        step(0, 3'b100, 0); check("flash.dw1", int'(dw_w[0]), 1);
        step(0, 3'b100, 0); check("flash.dw2", int'(dw_w[0]), 0);
        step(0, 3'b100, 0); check("flash.dw3", int'(dw_w[0]), 1);
        step(0, 3'b010, 0); check("flash.idle_dw", int'(dw_w[0]), 1);

        // WALK_CYCLES=3 with 2-cycle red: walk drops when r falls, no CLEAR.
        step(1, 3'b100, 0); step(0, 3'b100, 0); step(0, 3'b010, 0); step(0, 3'b010, 0);
        step(0, 3'b001, 0); step(0, 3'b001, 1);
        step(0, 3'b100, 0); check("wc3.walk_a", int'(walk_w[1]), 1);
        step(0, 3'b100, 0); check("wc3.walk_b", int'(walk_w[1]), 1);
        check("wc1.walk_b", int'(walk_w[0]), 0);
        step(0, 3'b010, 0); check("wc3.walk_c", int'(walk_w[1]), 0);
        check("wc3.dw_c", int'(dw_w[1]), 1);

        // Reset mid-WALK.
        step(0, 3'b010, 0); step(0, 3'b001, 0); step(0, 3'b001, 1);
        step(0, 3'b100, 0); check("midwalk.pre", int'(walk_w[0]), 1);
        step(1, 3'b100, 0);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("midwalk%0d.walk", m), int'(walk_w[m]), 0);
            check($sformatf("midwalk%0d.dw", m), int'(dw_w[m]), 1);
            check($sformatf("midwalk%0d.cnt", m), int'(cnt_w[m]), 0);
        end

        // 17 served requests: counter saturates at 15.
        step(0, 3'b100, 0);
        for (int k = 0; k < 17; k++) begin
            step(0, 3'b010, 0); step(0, 3'b010, 0);
            step(0, 3'b001, 0); step(0, 3'b001, 1);
            step(0, 3'b100, 0); step(0, 3'b100, 0);
        end
        check("sat.cnt0", int'(cnt_w[0]), 15);
        check("sat.cnt1", int'(cnt_w[1]), 15);

        // Random light stream with occasional faults and resets.
        gidx = 0; glen = 2;
        step(1, 3'b100, 0);
        for (int i = 0; i < 3000; i++) begin
            if (glen == 0) begin
                gidx = (gidx + 1) % 3;
                glen = ($urandom_range(0, 24) == 0) ? 5 : int'($urandom_range(1, 4));
            end
            glen--;
            rgb = 3'b100 >> gidx;
            if ($urandom_range(0, 199) == 0) rgb = rgb | (3'b100 >> ((gidx + 1) % 3));
            if ($urandom_range(0, 199) == 0) begin
                gidx = (gidx + 2) % 3;
                rgb  = 3'b100 >> gidx;
            end
            step($urandom_range(0, 59) == 0, rgb, $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
